// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, load, shift, rotate
// and an autonomous LSB-first serialise sequence.
module universal_shift_reg #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d_in,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  output logic [WIDTH-1:0] q_out,
  output logic             ser_out_r,
  output logic             ser_out_l,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SER  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // State register; reset abandons any running sequence
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      q_q     <= RESET_VAL;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state: mode decode in IDLE, fixed right shift in SER
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (mode)
          3'b000: q_d = q_q;
          3'b001: q_d = d_in;
          3'b010: q_d = {ser_in_l, q_q[WIDTH-1:1]};
          3'b011: q_d = {q_q[WIDTH-2:0], ser_in_r};
          3'b100: q_d = {q_q[0], q_q[WIDTH-1:1]};
          3'b101: q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          3'b110: begin
            q_d     = d_in;
            count_d = CNT_MAX;
            busy_d  = 1'b1;
            state_d = SER;
          end
          3'b111: q_d = q_q;
          default: q_d = q_q;
        endcase
      end
      SER: begin
        q_d = {ser_in_l, q_q[WIDTH-1:1]};
        if (count_q != '0) begin
          count_d = count_q - CW'(1);
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign q_out     = q_q;
  assign ser_out_r = q_q[0];
  assign ser_out_l = q_q[WIDTH-1];
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
